mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Target side of the core's memory bus. Answers the core's instruction fetches (i_addr/i_data) and its data strobes (strobe/mem_rw/d_addr).
- Holds a word-addressed RAM window and a 4-word MMIO window:
  - console TX FIFO with a byte ready/valid output
  - status register
  - halt control register, which drives the wired-OR halt net
  - free-running cycle counter
- Sits beside Core at SoC top level. Both share clk and reset_n.

Parameters:
- ADDR_BITS, 12, RAM size is 2^ADDR_BITS 32-bit words.
- RAM_BASE, 32'h0000_1000, word address of RAM word 0. Must be aligned to 2^ADDR_BITS.
- IO_BASE, 32'h0000_0100, word address of the MMIO block (4 words).
- FIFO_DEPTH, 8, TX FIFO entries. Power of two, at least 2.
- INIT_FILE, "", hex image loaded into RAM at elaboration. Empty string means no load.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; synchronous, active-low
- i_addr  in  32  instruction word address
- i_data  out  32  instruction word, registered
- strobe  in  1  data access qualifier, asserted for one cycle
- mem_rw  in  1  1 = write, 0 = read; meaningful only with strobe
- d_addr  in  32  data word address
- d_out  in  32  write data from the core
- d_in  out  32  read data to the core, registered
- halt  out  1  this block's driver onto the wired-OR halt net
- tx_data  out  8  head byte of the TX FIFO
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  sink accepts tx_data this cycle
- err  out  1  one-cycle pulse on a strobe to an unmapped address

Behaviour:
- Reset values: i_data=0, d_in=0, halt=0, tx_valid=0, err=0, FIFO empty, overflow=0, cycle=0. RAM contents are not reset.
- Address decode:
  - RAM hit when (addr - RAM_BASE) < 2^ADDR_BITS, unsigned.
  - IO hit when addr[31:2] == IO_BASE[31:2]; offset is addr[1:0].
  - Anything else is unmapped.
- Instruction port: every cycle, i_data <= ram[i_addr-RAM_BASE] on a RAM hit, else 0. Latency is 1 cycle.
- Data read: every cycle, independent of strobe, d_in <= value at d_addr. Latency is 1 cycle, so d_in is valid the cycle after d_addr settles.
  - Reads have no side effects.
  - Unmapped reads return 0.
- Data write, when strobe && mem_rw:
  - RAM hit: ram word <= d_out.
  - IO offset 0 (TX): push d_out[7:0] into the FIFO.
  - IO offset 1 (STATUS): if d_out[31]=1, clear overflow.
  - IO offset 2 (HALT): halt <= d_out[0].
  - IO offset 3 (CYCLE): ignored.
- Read/write collision: a write and a read of the same RAM word in the same cycle returns the old value (read-first). The same holds for the i-port.
- STATUS read value: {overflow, 23'b0, full, empty, 6'(count)}. Count saturates the 6-bit field only if FIFO_DEPTH > 63.
- HALT read returns {31'b0, halt}.
- CYCLE read returns the counter. The counter increments every cycle after reset and wraps from FFFFFFFF to 0.
- TX FIFO rules:
  - pop = tx_valid && tx_ready.
  - A push is accepted iff !full || pop.
  - A rejected push sets overflow (sticky) and the data is dropped.
  - Simultaneous push and pop: count is unchanged and the head advances.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_data/tx_valid come directly from the head and count; no bubble after a push. A push into an empty FIFO shows tx_valid=1 on the next cycle.
- err: registered. Pulses for 1 cycle the cycle after a strobe to an unmapped address, read or write. Writes to unmapped addresses have no other effect.
- Reset mid-operation: a pending FIFO content is discarded, halt drops to 0, and a coincident write is ignored.

Decomposition:
- common.vh gains IO offsets: IO_TX=0, IO_STATUS=1, IO_HALT=2, IO_CYCLE=3. It also gains the STATUS bit positions: OVF=31, FULL=7, EMPTY=6.
- Sub-module tx_fifo(clk, reset_n, push, din, pop, dout, full, empty, count), parameterised by depth. It holds the FIFO storage, pointers and count.
- The RAM array, decode, MMIO registers and counter stay in mem_responder.

Test Plan:
- RAM round trip: write 32'hDEADBEEF to RAM_BASE+5 (strobe, mem_rw=1), then hold d_addr=RAM_BASE+5 with no strobe -> d_in=DEADBEEF one cycle later; i_addr=RAM_BASE+5 -> i_data=DEADBEEF one cycle later.
- FIFO flow: tx_ready=0, push 'A','B' -> STATUS reads count=2, empty=0. Raise tx_ready -> tx_data 8'h41 then 8'h42 on consecutive cycles, then tx_valid=0 and STATUS empty=1.
- Overflow: tx_ready=0, push 9 bytes -> full=1, overflow=1, FIFO holds the first 8. Write STATUS 32'h8000_0000 -> overflow=0. Push while full with tx_ready=1 in the same cycle -> accepted, overflow stays 0, count stays 8.
- Halt: write HALT 1 -> halt=1 next cycle, reads back 1. Write 0 -> halt=0. Assert reset_n=0 while halt=1 -> halt=0 after the clock edge.
- Cycle and wrap: after reset, CYCLE read at cycle N returns N-1 (registered read). Force the counter to FFFFFFFF via the bench -> the following read shows 0.
- Unmapped access: strobe a read at 32'h0000_0000 (with RAM_BASE, IO_BASE at defaults) -> err=1 for exactly one cycle, d_in=0. Same for a write, with no RAM or MMIO state change.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: MMIO word offsets and STATUS bit positions.
package mem_responder_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] IO_TX     = 2'd0;
  localparam logic [1:0] IO_STATUS = 2'd1;
  localparam logic [1:0] IO_HALT   = 2'd2;
  localparam logic [1:0] IO_CYCLE  = 2'd3;

  localparam int STAT_OVF   = 31;
  localparam int STAT_FULL  = 7;
  localparam int STAT_EMPTY = 6;

endpackage

// File: rtl/mem_responder_tx_fifo.sv
// Byte FIFO feeding the console TX port; head byte is presented combinationally.
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Bus target for the core: word-addressed RAM window plus a 4-word MMIO block
// (console TX FIFO, status, halt control, free-running cycle counter).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          ADDR_BITS  = 12,
  parameter logic [31:0] RAM_BASE   = 32'h0000_1000,
  parameter logic [31:0] IO_BASE    = 32'h0000_0100,
  parameter int          FIFO_DEPTH = 8,
  parameter string       INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       i_addr,
  output logic [DATA_W-1:0] i_data,
  input  logic              strobe,
  input  logic              mem_rw,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_out,
  output logic [DATA_W-1:0] d_in,
  output logic              halt,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              err
);

  localparam int RAM_WORDS = 1 << ADDR_BITS;
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] ram [RAM_WORDS];

  function automatic logic [5:0] sat_count6(input logic [CW-1:0] c);
    if (32'(c) > 32'd63) return 6'd63;
    return 6'(c);
  endfunction

  logic [31:0]       i_off, d_off;
  logic              i_ram, d_ram, d_io, wr;
  logic              ovf_flag;
  logic [31:0]       cycle_cnt;
  logic [DATA_W-1:0] rd_val;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  // Unsigned subtract makes addresses below the base wrap far out of range.
  assign i_off = i_addr - RAM_BASE;
  assign d_off = d_addr - RAM_BASE;
  assign i_ram = (i_off[31:ADDR_BITS] == '0);
  assign d_ram = (d_off[31:ADDR_BITS] == '0);
  assign d_io  = (d_addr[31:2] == IO_BASE[31:2]);
  assign wr    = strobe && mem_rw;

  assign fifo_push = wr && d_io && (d_addr[1:0] == IO_TX);
  assign fifo_pop  = tx_valid && tx_ready;
  assign tx_valid  = !fifo_empty;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (d_out[7:0]),
    .pop     (fifo_pop),
    .dout    (tx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    rd_val = '0;
    if (d_ram) begin
      rd_val = ram[d_off[ADDR_BITS-1:0]];
    end else if (d_io) begin
      case (d_addr[1:0])
        IO_STATUS: begin
          rd_val[STAT_OVF]   = ovf_flag;
          rd_val[STAT_FULL]  = fifo_full;
          rd_val[STAT_EMPTY] = fifo_empty;
          rd_val[5:0]        = sat_count6(fifo_count);
        end
        IO_HALT:  rd_val = {31'b0, halt};
        IO_CYCLE: rd_val = cycle_cnt;
        default:  rd_val = '0;
      endcase
    end
  end

  // Write port; nonblocking update gives read-first behaviour on both read ports.
  always_ff @(posedge clk) begin
    if (reset_n && wr && d_ram) ram[d_off[ADDR_BITS-1:0]] <= d_out;
  end

  // Registered read stage and MMIO control state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_data    <= '0;
      d_in      <= '0;
      halt      <= 1'b0;
      err       <= 1'b0;
      ovf_flag  <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      i_data    <= i_ram ? ram[i_off[ADDR_BITS-1:0]] : '0;
      d_in      <= rd_val;
      err       <= strobe && !d_ram && !d_io;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (wr && d_io && (d_addr[1:0] == IO_HALT)) halt <= d_out[0];
      if (fifo_push && fifo_full && !fifo_pop)
        ovf_flag <= 1'b1;
      else if (wr && d_io && (d_addr[1:0] == IO_STATUS) && d_out[31])
        ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a scoreboard queue for registered read data.
module tb_mem_responder;

  localparam logic [31:0] RAM_BASE = 32'h0000_1000;
  localparam logic [31:0] IO_BASE  = 32'h0000_0100;
  localparam logic [31:0] A_TX     = IO_BASE + 32'd0;
  localparam logic [31:0] A_STAT   = IO_BASE + 32'd1;
  localparam logic [31:0] A_HALT   = IO_BASE + 32'd2;
  localparam logic [31:0] A_CYC    = IO_BASE + 32'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] i_addr, d_addr, d_out;
  logic [31:0] i_data, d_in;
  logic        strobe, mem_rw, tx_ready;
  logic        halt, tx_valid, err;
  logic [7:0]  tx_data;

  int n_total = 0;
  int n_pass  = 0;

  string       tag_q[$];
  bit          sel_q[$];
  logic [31:0] val_q[$];

  always #5 clk = ~clk;

  mem_responder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_addr   (i_addr),
    .i_data   (i_data),
    .strobe   (strobe),
    .mem_rw   (mem_rw),
    .d_addr   (d_addr),
    .d_out    (d_out),
    .d_in     (d_in),
    .halt     (halt),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // sel 0 = d_in, 1 = i_data; checked after the next clock edge
  task automatic expect_out(input string tag, input bit sel, input logic [31:0] val);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    val_q.push_back(val);
  endtask

  task automatic tick();
    string       t;
    bit          s;
    logic [31:0] v;
    @(posedge clk);
    #1;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      v = val_q.pop_front();
      check(t, s ? i_data : d_in, v);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    d_addr = a;
    d_out  = d;
    strobe = 1'b1;
    mem_rw = 1'b1;
    tick();
    strobe = 1'b0;
    mem_rw = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    d_addr = a;
    expect_out(tag, 1'b0, exp);
    tick();
  endtask

  initial begin
    logic [31:0] prev;
    bit          found;

    reset_n  = 1'b0;
    i_addr   = '0;
    d_addr   = A_CYC;
    d_out    = '0;
    strobe   = 1'b0;
    mem_rw   = 1'b0;
    tx_ready = 1'b0;
    tick();
    tick();
    check("rst_i_data", i_data, 32'h0);
    check("rst_d_in", d_in, 32'h0);
    check("rst_halt", {31'b0, halt}, 32'h0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);

    // Cycle counter: k-th edge after reset release reads k-1
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_out("cycle_count", 1'b0, 32'(k));
      tick();
    end
    rd("rst_status", A_STAT, 32'h0000_0040);

    // RAM round trip, read-first collision, top word, unmapped i-port
    wr(RAM_BASE + 32'd5, 32'hDEAD_BEEF);
    d_addr = RAM_BASE + 32'd5;
    i_addr = RAM_BASE + 32'd5;
    expect_out("ram_d_read", 1'b0, 32'hDEAD_BEEF);
    expect_out("ram_i_read", 1'b1, 32'hDEAD_BEEF);
    tick();
    d_out  = 32'h1234_5678;
    strobe = 1'b1;
    mem_rw = 1'b1;
    expect_out("collide_d_old", 1'b0, 32'hDEAD_BEEF);
    expect_out("collide_i_old", 1'b1, 32'hDEAD_BEEF);
    tick();
    strobe = 1'b0;
    mem_rw = 1'b0;
    expect_out("collide_d_new", 1'b0, 32'h1234_5678);
    expect_out("collide_i_new", 1'b1, 32'h1234_5678);
    tick();
    wr(RAM_BASE + 32'd4095, 32'hCAFE_F00D);
    i_addr = RAM_BASE + 32'd4095;
    expect_out("ram_top_word", 1'b1, 32'hCAFE_F00D);
    tick();
    i_addr = 32'h0;
    expect_out("i_unmapped", 1'b1, 32'h0);
    tick();

    // FIFO flow
    wr(A_TX, 32'h41);
    check("push_valid", {31'b0, tx_valid}, 32'h1);
    check("push_head", {24'b0, tx_data}, 32'h41);
    wr(A_TX, 32'h42);
    rd("status_two", A_STAT, 32'h0000_0002);
    tx_ready = 1'b1;
    check("drain_a", {24'b0, tx_data}, 32'h41);
    tick();
    check("drain_b", {24'b0, tx_data}, 32'h42);
    check("drain_b_valid", {31'b0, tx_valid}, 32'h1);
    tick();
    check("drained_valid", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    rd("status_empty", A_STAT, 32'h0000_0040);

    // Overflow: 9 pushes into an 8-deep FIFO
    for (int i = 0; i < 9; i++) wr(A_TX, 32'h10 + 32'(i));
    check("ovf_head", {24'b0, tx_data}, 32'h10);
    rd("status_ovf", A_STAT, 32'h8000_0088);
    wr(A_STAT, 32'h8000_0000);
    rd("status_ovf_clr", A_STAT, 32'h0000_0088);
    tx_ready = 1'b1;
    wr(A_TX, 32'h55);
    tx_ready = 1'b0;
    rd("status_full_pp", A_STAT, 32'h0000_0088);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_order", {24'b0, tx_data}, (i < 7) ? 32'h11 + 32'(i) : 32'h55);
      tick();
    end
    check("drain_done", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Halt register and reset mid-operation
    wr(A_HALT, 32'h1);
    check("halt_set", {31'b0, halt}, 32'h1);
    rd("halt_read", A_HALT, 32'h1);
    wr(A_HALT, 32'h0);
    check("halt_clr", {31'b0, halt}, 32'h0);
    wr(A_HALT, 32'h1);
    wr(RAM_BASE + 32'd7, 32'h1111_1111);
    wr(A_TX, 32'h77);
    check("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
    reset_n = 1'b0;
    d_addr  = RAM_BASE + 32'd7;
    d_out   = 32'h2222_2222;
    strobe  = 1'b1;
    mem_rw  = 1'b1;
    tick();
    check("rst_halt_drop", {31'b0, halt}, 32'h0);
    check("rst_fifo_drop", {31'b0, tx_valid}, 32'h0);
    strobe  = 1'b0;
    mem_rw  = 1'b0;
    reset_n = 1'b1;
    rd("rst_write_ignored", RAM_BASE + 32'd7, 32'h1111_1111);

    // Counter wrap: preload all-ones, expect FFFFFFFF then 0 then 1
    d_addr = A_CYC;
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.cycle_cnt;
    prev  = d_in;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      tick();
      if (d_in == 32'h0) found = 1'b1;
      else prev = d_in;
    end
    check("wrap_zero_seen", {31'b0, found}, 32'h1);
    check("wrap_prev_ones", prev, 32'hFFFF_FFFF);
    tick();
    check("wrap_then_one", d_in, 32'h1);

    // Unmapped read and write
    d_addr = 32'h0;
    strobe = 1'b1;
    expect_out("unmapped_rd_data", 1'b0, 32'h0);
    tick();
    strobe = 1'b0;
    check("unmapped_rd_err", {31'b0, err}, 32'h1);
    tick();
    check("unmapped_err_one", {31'b0, err}, 32'h0);
    wr(32'h0, 32'hFFFF_FFFF);
    check("unmapped_wr_err", {31'b0, err}, 32'h1);
    rd("unmapped_no_halt", A_HALT, 32'h0);
    check("unmapped_wr_err_end", {31'b0, err}, 32'h0);
    rd("unmapped_status", A_STAT, 32'h0000_0040);
    rd("unmapped_ram", RAM_BASE + 32'd5, 32'h1234_5678);
    d_addr = RAM_BASE + 32'd4096;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    check("ram_past_top_err", {31'b0, err}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
